// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit : multi-cycle radix-2 restoring divider for the EX stage (MIPS
//            DIV / DIVU). Quotient goes to LO, remainder to HI.
//
// Ports:
//   clk_i       clock, all state changes on the rising edge
//   rst_i       synchronous active-high reset
//   start_i     DIV/DIVU present in EX (held high by the stall until done)
//   signed_i    1 = DIV (two's complement), 0 = DIVU
//   dividend_i  rs operand, sampled at accept
//   divisor_i   rt operand, sampled at accept
//   annul_i     pipeline flush, cancels any operation
//   ok_o        EX may advance (controller's ex_ok), combinational
//   busy_o      an operation is in progress (BUSY or DONE)
//   quot_o      quotient (held until the next completion)
//   rem_o       remainder (held until the next completion)
//
// Optional feature: define DIV_ZERO_FAST_EN to complete a divide by zero
// in one cycle (accept -> DONE) instead of the full iteration sequence.
// -----------------------------------------------------------------------------
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             annul_i,
   output logic             ok_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] part;      // partial remainder
   logic [WIDTH-1:0] dvd;       // dividend bits shifting out, quotient bits shifting in
   logic [WIDTH-1:0] dvs;       // divisor magnitude
   logic             q_neg;
   logic             r_neg;

   logic             accept;
   logic             last_iter;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   sh;
   logic [WIDTH+1:0] diff;
   logic [WIDTH-1:0] part_nxt;
   logic [WIDTH-1:0] dvd_nxt;
   logic             div_zero;

   // Two's complement negation when neg is set, pass-through otherwise.
   function automatic logic [WIDTH-1:0] fixup(input logic [WIDTH-1:0] mag,
                                              input logic neg);
      return neg ? (~mag + {{(WIDTH-1){1'b0}}, 1'b1}) : mag;
   endfunction

   assign accept    = (state == IDLE) & start_i & ~annul_i;
   assign last_iter = (cnt == CNT_W'(WIDTH-1));
   assign busy_o    = (state != IDLE);
   assign ok_o      = annul_i | ~(((state == IDLE) & start_i) | (state == BUSY));

`ifdef DIV_ZERO_FAST_EN
   assign div_zero = (divisor_i == {WIDTH{1'b0}});
`else
   assign div_zero = 1'b0;
`endif

   // Operand sign extraction and magnitude conversion at accept.
   always_comb begin
      a_neg = signed_i & dividend_i[WIDTH-1];
      b_neg = signed_i & divisor_i[WIDTH-1];
      a_mag = fixup(dividend_i, a_neg);
      b_mag = fixup(divisor_i, b_neg);
   end

   // One restoring iteration: shift in the next dividend bit, trial-subtract
   // in WIDTH+2 bits so the top bit is a clean borrow flag.
   always_comb begin
      sh   = {part, dvd[WIDTH-1]};
      diff = {1'b0, sh} - {2'b00, dvs};
      if (!diff[WIDTH+1]) begin
         part_nxt = diff[WIDTH-1:0];
         dvd_nxt  = {dvd[WIDTH-2:0], 1'b1};
      end else begin
         part_nxt = sh[WIDTH-1:0];
         dvd_nxt  = {dvd[WIDTH-2:0], 1'b0};
      end
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a flush always returns to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = div_zero ? DONE : BUSY;
            end else begin
               state_nxt = IDLE;
            end
         end
         BUSY: begin
            if (last_iter) begin
               state_nxt = DONE;
            end else begin
               state_nxt = BUSY;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (annul_i) begin
         state_nxt = IDLE;
      end else begin
         state_nxt = state_nxt;
      end
   end

   // Datapath: operand capture, iteration, and result registration.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt    <= {CNT_W{1'b0}};
         part   <= {WIDTH{1'b0}};
         dvd    <= {WIDTH{1'b0}};
         dvs    <= {WIDTH{1'b0}};
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         quot_o <= {WIDTH{1'b0}};
         rem_o  <= {WIDTH{1'b0}};
      end else if (accept) begin
         dvd   <= a_mag;
         dvs   <= b_mag;
         part  <= {WIDTH{1'b0}};
         cnt   <= {CNT_W{1'b0}};
         q_neg <= a_neg ^ b_neg;
         r_neg <= a_neg;
         // Fast divide-by-zero: magnitudes are all-ones / dividend.
         if (div_zero) begin
            quot_o <= fixup({WIDTH{1'b1}}, a_neg ^ b_neg);
            rem_o  <= fixup(a_mag, a_neg);
         end
      end else if ((state == BUSY) && !annul_i) begin
         part <= part_nxt;
         dvd  <= dvd_nxt;
         cnt  <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         if (last_iter) begin
            quot_o <= fixup(dvd_nxt, q_neg);
            rem_o  <= fixup(part_nxt, r_neg);
         end
      end
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage; executes MIPS DIV/DIVU.
- Produces the EX-complete signal that the pipeline stall/flush controller consumes as ex_ok: EX holds all stages while a division is in flight.
- Writes quotient to LO and remainder to HI through EX->MEM.
- Cancelled by the controller's flush output.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous active-high reset.
- start_i  input  1  DIV/DIVU instruction present in EX; held high by the stall until completion.
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i.
- dividend_i  input  WIDTH  rs operand; sampled at accept.
- divisor_i  input  WIDTH  rt operand; sampled at accept.
- annul_i  input  1  pipeline flush; cancels any operation.
- ok_o  input-facing output  1  EX may advance (feeds the controller's ex_ok).
- busy_o  output  1  an operation is in progress (IDLE excluded).
- quot_o  output  WIDTH  quotient, to LO.
- rem_o  output  WIDTH  remainder, to HI.

Behaviour:
- Reset:
  - state=IDLE, counter=0, quot_o=0, rem_o=0, busy_o=0.
  - ok_o=1 while start_i is low.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If start_i=1 and annul_i=0: accept the operation (cycle 0).
    - Latch magnitudes of the operands; in signed mode, negate if the MSB is set.
    - Latch the sign of the quotient (dividend sign XOR divisor sign) and the sign of the remainder (dividend sign).
    - Clear the partial remainder; counter=0; go to BUSY.
- BUSY:
  - One quotient bit per cycle, MSB first.
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor in WIDTH+1 bits; if non-negative, keep the difference and set quotient bit=1.
  - counter increments each cycle; after WIDTH iterations (cycles 1..32), go to DONE.
  - On that transition, register quot_o and rem_o with sign fixup: negate the quotient if its sign is set; negate the remainder if its sign is set (signed mode only).
- DONE:
  - Lasts exactly one cycle (cycle 33); quot_o and rem_o are valid.
  - start_i is ignored here: it is the same instruction still in EX. Unconditionally go to IDLE.
- ok_o is combinational:
  - ok_o = annul_i | ~((state==IDLE & start_i) | state==BUSY).
  - ok_o is therefore low from the accept cycle through the last BUSY cycle, and high in DONE.
- Latency: accept to result = 33 cycles; the EX instruction advances on the DONE edge.
- quot_o and rem_o hold their value until the next BUSY->DONE transition. They are not cleared in IDLE.
- annul_i=1 in any state:
  - Next state is IDLE; the result registers are left unchanged.
  - annul_i together with start_i in IDLE does not accept the operation.
- Divide by zero (architecturally undefined) is fixed for determinism:
  - Full 33-cycle latency.
  - Unsigned: quotient=all ones, remainder=dividend.
  - Signed: the fixup is then applied to these magnitudes.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000 (wraps), remainder=0.
- rst_i overrides annul_i and start_i; reset mid-operation aborts to IDLE and clears the results.
- Back-to-back divides: IDLE after DONE accepts the next start_i one cycle later.
  - Minimum issue spacing is 34 cycles.

Optional Feature:
- Macro DIV_ZERO_FAST_EN.
- When defined: a divisor of zero detected at accept skips BUSY. The next state is DONE directly with the divide-by-zero results above.
  - ok_o is low for the accept cycle only.
  - Result valid at cycle 1.
- When undefined: divide by zero takes the full 33 cycles, and no zero-detect logic is synthesised.

Test Plan:
- DIVU 100 / 7, start at cycle 0:
  - ok_o=0 for cycles 0..32.
  - ok_o=1 at cycle 33 with quot_o=14, rem_o=2.
  - IDLE at cycle 34.
- DIV -7 / 2 (0xFFFFFFF9 / 0x00000002) -> quot_o=0xFFFFFFFD, rem_o=0xFFFFFFFF at cycle 33.
  - DIV 7 / -2 -> quot_o=0xFFFFFFFD, rem_o=0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> quot_o=0x80000000, rem_o=0.
  - DIVU of the same operands -> quot_o=0, rem_o=0x80000000.
- DIVU 0x12345678 / 0:
  - Macro off: quot_o=0xFFFFFFFF, rem_o=0x12345678 at cycle 33.
  - Macro on: same values at cycle 1, with ok_o high at cycle 1.
- Start DIVU 100 / 7, then pulse annul_i at cycle 10:
  - IDLE at cycle 11; ok_o=1; quot_o and rem_o still hold the previous values.
  - Start 50 / 5 at cycle 12 -> quot_o=10, rem_o=0 at cycle 45.
- rst_i at cycle 20 of an operation:
  - Next cycle: IDLE, quot_o=0, rem_o=0, busy_o=0.
  - ok_o=1 with start_i low.
